det_event_monitor: RTL and testbench

Downstream consumer of the serial sequence detector's registered match pulse `Z`. It counts matches and measures the gap in clock cycles between consecutive matches. Gaps are buffered in a small first-word-fall-through FIFO that a host reads with a valid/read handshake. Match pulses stay in the detector's clock domain; the monitor adds no synchronisation.

---
 rtl/det_event_monitor.sv | 53 +++++
 tb/tb_det_event_monitor.sv | 134 +++++++++++++
 2 files changed

// File: rtl/det_event_monitor.sv
// det_event_monitor: counts detector matches and queues inter-match gaps in a FWFT FIFO.
module det_event_monitor #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       z_in,
    input  logic                       clr,
    input  logic                       rd_en,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [GAP_W-1:0]           gap_dout,
    output logic                       gap_valid,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    logic [GAP_W-1:0] mem [DEPTH];
    logic [GAP_W-1:0] t, gap;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic pop, wr;
    // gap doubles as the saturating timer increment
    assign gap = (t == '1) ? t : t + 1'b1;
    assign gap_valid = level != '0;
    assign fifo_full = level == FULL_LVL;
    assign pop = rd_en && gap_valid;
    assign wr = z_in && (!fifo_full || pop);
    assign gap_dout = gap_valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            t         <= '0;
            match_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
        end else begin
            t         <= z_in ? '0 : gap;
            match_cnt <= (z_in && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level     <= level + LW'(wr) - LW'(pop);
            if (z_in && fifo_full && !pop) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && !clr && wr) mem[wr_ptr] <= gap;
    end
endmodule

// File: tb/tb_det_event_monitor.sv
// tb_det_event_monitor: directed checks of gap timing, saturation, FIFO full/overflow and clear priority.
module tb_det_event_monitor;
    logic clk = 1'b0, rst = 1'b0, z_in = 1'b0, clr = 1'b0, rd_en = 1'b0;
    logic [7:0] match_cnt, gap_dout;
    logic gap_valid, fifo_full, overflow;
    logic [2:0] level;
    int n_checks = 0, n_fail = 0;

    det_event_monitor #(.CNT_W(8), .GAP_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .z_in(z_in), .clr(clr), .rd_en(rd_en),
        .match_cnt(match_cnt), .gap_dout(gap_dout), .gap_valid(gap_valid),
        .fifo_full(fifo_full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset values
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(gap_valid), 0);
        chk("rst_dout", 32'(gap_dout), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_full", 32'(fifo_full), 0);
        // basic gaps: pulses at edges 5, 9, 10
        tick(4);
        z_in = 1'b1; tick(1); z_in = 1'b0;
        tick(3);
        z_in = 1'b1; tick(2); z_in = 1'b0;
        chk("basic_cnt", 32'(match_cnt), 3);
        chk("basic_level", 32'(level), 3);
        chk("basic_valid", 32'(gap_valid), 1);
        chk("basic_gap0", 32'(gap_dout), 5);
        rd_en = 1'b1;
        tick(1);
        chk("basic_gap1", 32'(gap_dout), 4);
        chk("basic_level1", 32'(level), 2);
        tick(1);
        chk("basic_gap2", 32'(gap_dout), 1);
        tick(1);
        chk("basic_empty_valid", 32'(gap_valid), 0);
        chk("basic_empty_dout", 32'(gap_dout), 0);
        chk("basic_empty_level", 32'(level), 0);
        tick(1);
        chk("underflow_ignored", 32'(level), 0);
        rd_en = 1'b0;
        // saturation
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(300);
        z_in = 1'b1; tick(1); z_in = 1'b0;
        chk("sat_gap", 32'(gap_dout), 255);
        chk("sat_level", 32'(level), 1);
        chk("sat_cnt1", 32'(match_cnt), 1);
        z_in = 1'b1; rd_en = 1'b1;
        tick(260);
        z_in = 1'b0; rd_en = 1'b0;
        chk("sat_cnt", 32'(match_cnt), 255);
        chk("sat_rw_level", 32'(level), 1);
        chk("sat_rw_dout", 32'(gap_dout), 1);
        chk("sat_rw_ovf", 32'(overflow), 0);
        // fill to full with pulses at edges 3, 6, 9, 12
        rst = 1'b1; tick(1); rst = 1'b0;
        repeat (4) begin
            tick(2);
            z_in = 1'b1; tick(1); z_in = 1'b0;
        end
        chk("full_flag", 32'(fifo_full), 1);
        chk("full_level", 32'(level), 4);
        chk("full_ovf0", 32'(overflow), 0);
        // push and pop together while full
        tick(4);
        z_in = 1'b1; rd_en = 1'b1; tick(1); rd_en = 1'b0;
        chk("fullrw_level", 32'(level), 4);
        chk("fullrw_ovf", 32'(overflow), 0);
        chk("fullrw_dout", 32'(gap_dout), 3);
        // push while full without pop is dropped
        tick(1); z_in = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_cnt", 32'(match_cnt), 6);
        rd_en = 1'b1;
        tick(1); chk("ovf_pop1", 32'(gap_dout), 3);
        tick(1); chk("ovf_pop2", 32'(gap_dout), 3);
        tick(1); chk("ovf_pop3", 32'(gap_dout), 5);
        tick(1);
        chk("ovf_pop4_valid", 32'(gap_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        rd_en = 1'b0;
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_cnt0", 32'(match_cnt), 0);
        // clear priority with level 2 and count 7
        z_in = 1'b1; rd_en = 1'b1;
        tick(6);
        rd_en = 1'b0;
        tick(1);
        z_in = 1'b0;
        chk("pre_clr_cnt", 32'(match_cnt), 7);
        chk("pre_clr_level", 32'(level), 2);
        clr = 1'b1; z_in = 1'b1; rd_en = 1'b1;
        tick(1);
        clr = 1'b0; z_in = 1'b0; rd_en = 1'b0;
        chk("clr_cnt", 32'(match_cnt), 0);
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(gap_valid), 0);
        chk("clr_dout", 32'(gap_dout), 0);
        chk("clr_full", 32'(fifo_full), 0);
        tick(5);
        z_in = 1'b1; tick(1); z_in = 1'b0;
        chk("post_clr_gap", 32'(gap_dout), 6);
        chk("post_clr_cnt", 32'(match_cnt), 1);
        chk("post_clr_level", 32'(level), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
